// File: rtl/llc_decode_scheduler_pkg.sv
// Shared types and constants for the LLC input-decode scheduler.
package llc_decode_scheduler_pkg;

    // Scheduler phases: wait for work, decode, set/tag read, wait for process stage.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DECODE  = 2'd1,
        S_RDSET   = 2'd2,
        S_PROCESS = 2'd3
    } llc_dec_sched_state_t;

    // Consecutive CPU-request wins over a waiting DMA request before CPU requests are masked.
    localparam int LLC_REQ_STARVE_LIMIT = 4;

endpackage

// File: rtl/llc_starve_counter.sv
// Saturating streak counter with synchronous increment/clear and a limit-hit flag.
// The flag is taken straight from the count register, so it adds no extra delay.
module llc_starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
    localparam logic [W-1:0] ONE_W   = W'(1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // Next count: clear has priority, increment saturates at LIMIT, otherwise hold.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = {W{1'b0}};
        end else if (inc && (count_r != LIMIT_W)) begin
            count_next_s = count_r + ONE_W;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign hit = (count_r == LIMIT_W);

endmodule

// File: rtl/llc_decode_scheduler.sv
// LLC input-decode scheduler: sequences decode_en / rd_set_en, holds the
// pipeline until the process stage finishes, gates the raw channel valids to
// the decode cycle, and masks CPU requests once they have starved DMA long enough.
module llc_decode_scheduler
    import llc_decode_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = LLC_REQ_STARVE_LIMIT,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic llc_rst_tb_valid_in,
    input  logic llc_rsp_in_valid_in,
    input  logic llc_req_in_valid_in,
    input  logic llc_dma_req_in_valid_in,
    input  logic recall_pending,
    input  logic rst_stall,
    input  logic flush_stall,
    input  logic req_stall,
    input  logic decoder_idle,
    input  logic process_done,
    output logic decode_en,
    output logic rd_set_en,
    output logic llc_rst_tb_valid_int,
    output logic llc_rsp_in_valid_int,
    output logic llc_req_in_valid_int,
    output logic llc_dma_req_in_valid_int,
    output logic busy,
    output logic starve_active
);

    llc_dec_sched_state_t state_r;
    llc_dec_sched_state_t state_next_s;

    logic work_pending_s;
    logic hi_pri_s;
    logic streak_eval_s;
    logic streak_inc_s;
    logic streak_clr_s;

    assign work_pending_s = llc_rst_tb_valid_in | llc_rsp_in_valid_in | llc_req_in_valid_in
                          | llc_dma_req_in_valid_in | recall_pending | rst_stall | flush_stall;

    assign hi_pri_s = recall_pending | rst_stall | flush_stall
                    | llc_rst_tb_valid_in | llc_rsp_in_valid_in;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the decode-cycle enables and gated valids.
    always_comb begin
        state_next_s             = state_r;
        decode_en                = 1'b0;
        rd_set_en                = 1'b0;
        llc_rst_tb_valid_int     = 1'b0;
        llc_rsp_in_valid_int     = 1'b0;
        llc_req_in_valid_int     = 1'b0;
        llc_dma_req_in_valid_int = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (work_pending_s) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_DECODE: begin
                decode_en                = 1'b1;
                llc_rst_tb_valid_int     = llc_rst_tb_valid_in;
                llc_rsp_in_valid_int     = llc_rsp_in_valid_in;
                llc_req_in_valid_int     = llc_req_in_valid_in & ~starve_active;
                llc_dma_req_in_valid_int = llc_dma_req_in_valid_in;
                state_next_s             = S_RDSET;
            end
            S_RDSET: begin
                // An idle decode means nothing was picked; skip the process stage.
                if (decoder_idle) begin
                    state_next_s = S_IDLE;
                end else begin
                    rd_set_en    = 1'b1;
                    state_next_s = S_PROCESS;
                end
            end
            S_PROCESS: begin
                if (process_done) begin
                    if (work_pending_s) begin
                        state_next_s = S_DECODE;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end else begin
                    state_next_s = S_PROCESS;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    assign busy = (state_r != S_IDLE);

    // The streak only moves on a decode with no high-priority work and no stalled
    // request replay; any of those make the arbitration outcome irrelevant to DMA fairness.
    assign streak_eval_s = (state_r == S_DECODE) & ~hi_pri_s & ~req_stall;
    assign streak_inc_s  = streak_eval_s & llc_req_in_valid_int & llc_dma_req_in_valid_in;
    assign streak_clr_s  = streak_eval_s & (~llc_dma_req_in_valid_in
                                            | (starve_active & llc_dma_req_in_valid_in));

    llc_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve_counter (
        .clk (clk),
        .rst (rst),
        .inc (streak_inc_s),
        .clr (streak_clr_s),
        .hit (starve_active)
    );

endmodule

// File: doc/llc_decode_scheduler.md
Name: llc_decode_scheduler

Overview:
- Sequences the LLC input-decode pipeline. Generates decode_en and rd_set_en for the input decoder and holds the pipeline until the process stage reports completion.
- Gates the raw channel valids so the decoder's combinational get/pop strobes fire only in the decode cycle.
- Adds starvation protection: CPU requests can otherwise lose DMA requests indefinitely at fixed priority.
- Sits between the LLC input channel interfaces and the input decoder, inside the LLC core.

Parameters:
- STARVE_LIMIT, 4: consecutive CPU-request wins over a waiting DMA request before CPU requests are masked. Legal range 1..255.
- CNT_W, $clog2(STARVE_LIMIT+1): width of the streak counter. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- llc_rst_tb_valid_in, llc_rsp_in_valid_in, llc_req_in_valid_in, llc_dma_req_in_valid_in  in  1 each  raw channel valids
- recall_pending, rst_stall, flush_stall, req_stall  in  1 each  internal work/stall flags
- decoder_idle  in  1  registered idle flag from the decoder; valid in the cycle after decode_en
- process_done  in  1  process stage finished the current transaction
- decode_en  out  1  decoder output-flop enable
- rd_set_en  out  1  decoder set/tag-flop enable
- llc_rst_tb_valid_int, llc_rsp_in_valid_int, llc_req_in_valid_int, llc_dma_req_in_valid_int  out  1 each  gated valids to the decoder
- busy  out  1  state != S_IDLE
- starve_active  out  1  CPU-request mask engaged

Behaviour:
- Reset (async, rst=0): state=S_IDLE, streak=0. All outputs 0. Reset mid-transaction aborts it with no further enables.
- work_pending = any raw valid | recall_pending | rst_stall | flush_stall.
- hi_pri = recall_pending | rst_stall | flush_stall | llc_rst_tb_valid_in | llc_rsp_in_valid_in.
- S_IDLE: all enables 0. If work_pending, go to S_DECODE.
- S_DECODE (one cycle):
  - decode_en=1.
  - rst_tb, rsp and dma valids pass through.
  - req valid passes through as llc_req_in_valid_in & ~starve_active.
  - Next state is S_RDSET.
- S_RDSET (one cycle):
  - If decoder_idle=1: rd_set_en=0, go to S_IDLE.
  - Else: rd_set_en=1, go to S_PROCESS.
- S_PROCESS:
  - All enables 0.
  - On process_done: go to S_DECODE if work_pending, else S_IDLE.
- All gated valids are 0 outside S_DECODE.
- process_done is ignored in every state except S_PROCESS.
- Latency: valid at cycle t in S_IDLE gives decode_en at t+1 and rd_set_en at t+2. process_done at cycle p with work pending gives the next decode_en at p+1.
- Streak counter, evaluated only in S_DECODE with hi_pri=0 and req_stall=0:
  - Gated req valid=1 and raw dma valid=1: streak += 1, saturating at STARVE_LIMIT.
  - Raw dma valid=0: streak = 0.
  - starve_active=1 and raw dma valid=1 (DMA wins): streak = 0.
- In every other cycle the streak holds.
- starve_active = (streak == STARVE_LIMIT), registered through the counter with no extra delay.
- The stalled-request replay path inside the decoder is not masked and does not count toward the streak.
- Simultaneous events:
  - Reset dominates everything.
  - process_done together with new valids gives an immediate S_DECODE.
  - Valid deassertion during S_RDSET or S_PROCESS has no effect on the current transaction.
- Valid states are S_IDLE, S_DECODE, S_RDSET and S_PROCESS; any other encoding recovers to S_IDLE on the next clock.

Decomposition:
- cache_types.svh: llc_dec_sched_state_t enum {S_IDLE, S_DECODE, S_RDSET, S_PROCESS}, 2 bits.
- cache_consts.svh: LLC_REQ_STARVE_LIMIT (4), used as the STARVE_LIMIT default.
- One sub-module, llc_starve_counter: saturating counter with inc, clr, limit-hit output and parameterised width.
- FSM and valid gating live in the top module.

Test Plan:
- Single req: llc_req_in_valid_in=1 at cycle 0 from S_IDLE, decoder_idle=0 -> decode_en=1 at cycle 1, rd_set_en=1 at cycle 2. Then process_done at cycle 5 with no work -> busy=0 at cycle 6.
- Idle decode: rst_stall=0 and all valids 0 except a one-cycle dma pulse; decoder_idle=1 in S_RDSET -> rd_set_en stays 0, state S_IDLE next cycle, streak unchanged.
- Starvation (STARVE_LIMIT=4): req and dma valid held high, hi_pri=0, req_stall=0.
  - Transactions 1-4 -> llc_req_in_valid_int=1, streak 1..4.
  - Transaction 5 -> starve_active=1, llc_req_in_valid_int=0, llc_dma_req_in_valid_int=1, streak cleared after it.
- Priority holds the streak: rsp valid high alongside req and dma for 10 transactions -> streak stays 0 and starve_active never asserts.
- Back-to-back: process_done coincident with new llc_rsp_in_valid_in -> decode_en the next cycle with no S_IDLE visit.
- Reset mid-op: rst=0 asserted in S_PROCESS with streak=3 -> decode_en, rd_set_en, busy and starve_active all 0 immediately, streak=0. After release, the first valid still takes 1 cycle to decode_en.
